seq_pattern_gen: RTL and testbench

Serial bit-pattern transmitter, the driving end of the team's serial sequence-detector datapath. It latches a parallel pattern with a length, repeat count and inter-pattern gap, then shifts the pattern out MSB-first, one bit per clock, on a single-bit stream. The output port is intended to connect directly to a detector's din input, both in system use and in loopback benches. It provides a start/busy/done handshake to the controlling logic.

---
 rtl/seq_pattern_gen.sv | 100 ++++++++++
 tb/tb_seq_pattern_gen.sv | 101 ++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern transmitter with repeat/gap control and start/busy/done handshake
module seq_pattern_gen #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = 4,
  parameter int RPT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [RPT_W-1:0]   reps,
  input  logic [GAP_W-1:0]   gap,
  output logic               dout,
  output logic               dout_valid,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic               err
);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
  state_t state, nxt;
  logic [MAX_LEN-1:0] sr, pat_a, aligned;
  logic [LEN_W-1:0] len_l, cnt, shamt;
  logic [RPT_W-1:0] rcnt;
  logic [GAP_W-1:0] gap_l, gcnt;
  logic len_ok, accept, last_bit;
  assign len_ok = len != '0 && len <= LEN_W'(MAX_LEN);
  assign accept = state == IDLE && start && len_ok;
  assign last_bit = cnt == '0;
  assign shamt = LEN_W'(MAX_LEN) - len;
  // left-align so the first bit to send always sits at the MSB of the shifter
  assign aligned = pattern << shamt;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    dout = 1'b0;
    dout_valid = 1'b0;
    ready = 1'b0;
    busy = 1'b1;
    done = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        busy = 1'b0;
        nxt = accept ? SHIFT : IDLE;
      end
      SHIFT: begin
        dout = sr[MAX_LEN-1];
        dout_valid = 1'b1;
        nxt = !last_bit ? SHIFT : rcnt == '0 ? DONE : gap_l != '0 ? GAP : SHIFT;
      end
      GAP: nxt = gcnt == '0 ? SHIFT : GAP;
      default: begin
        done = 1'b1;
        nxt = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      sr <= '0;
      pat_a <= '0;
      len_l <= '0;
      cnt <= '0;
      rcnt <= '0;
      gap_l <= '0;
      gcnt <= '0;
      err <= 1'b0;
    end else begin
      err <= state == IDLE && start && !len_ok;
      case (state)
        IDLE:
          if (accept) begin
            sr <= aligned;
            pat_a <= aligned;
            len_l <= len;
            cnt <= len - 1'b1;
            rcnt <= reps;
            gap_l <= gap;
          end
        SHIFT:
          if (!last_bit) begin
            sr <= sr << 1;
            cnt <= cnt - 1'b1;
          end else begin
            // reload now so both the back-to-back and post-gap paths start ready
            sr <= pat_a;
            cnt <= len_l - 1'b1;
            gcnt <= gap_l - 1'b1;
            if (rcnt != '0) rcnt <= rcnt - 1'b1;
          end
        GAP: gcnt <= gcnt - 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed and random stimulus checked against a per-cycle expected-output queue
module tb_seq_pattern_gen;
  logic clk = 0, reset = 1, start = 0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0, reps = '0, gap = '0;
  logic dout, dout_valid, ready, busy, done, err;
  int n_cmp = 0, n_bad = 0;
  int q[$];
  bit err_pend = 0;

  always #5 clk = ~clk;

  seq_pattern_gen dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .gap(gap), .dout(dout), .dout_valid(dout_valid),
    .ready(ready), .busy(busy), .done(done), .err(err)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // queue codes per busy cycle: 0 gap, 1 done, 2 bit=0, 3 bit=1; empty queue means idle
  task automatic step(bit st, logic [7:0] p, int ln, int rp, int gp, bit rs);
    int e;
    bit idle;
    @(negedge clk);
    idle = q.size() == 0;
    e = idle ? -1 : q.pop_front();
    check("dout_valid", 32'(dout_valid), 32'(e >= 2));
    check("dout", 32'(dout), 32'(e == 3));
    check("done", 32'(done), 32'(e == 1));
    check("ready", 32'(ready), 32'(idle));
    check("busy", 32'(busy), 32'(!idle));
    check("err", 32'(err), 32'(err_pend));
    err_pend = 0;
    reset = rs;
    start = st;
    pattern = p;
    len = 4'(ln);
    reps = 4'(rp);
    gap = 4'(gp);
    if (rs) q.delete();
    else if (idle && st) begin
      if (ln < 1 || ln > 8) err_pend = 1;
      else begin
        for (int r = 0; r <= rp; r++) begin
          for (int i = ln - 1; i >= 0; i--) q.push_back(p[i] ? 3 : 2);
          if (r < rp) repeat (gp) q.push_back(0);
        end
        q.push_back(1);
      end
    end
  endtask

  task automatic run_out(bit noisy);
    while (q.size() != 0)
      step(noisy && $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 10),
           $urandom_range(0, 15), $urandom_range(0, 15), 0);
    step(0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    step(0, '0, 0, 0, 0, 0);
    step(1, 8'b101, 3, 0, 0, 0);
    run_out(0);
    step(1, 8'b10, 2, 2, 0, 0);
    run_out(0);
    step(1, 8'b101, 3, 1, 2, 0);
    run_out(0);
    step(1, 8'hFF, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);
    step(1, 8'hFF, 9, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);
    step(1, 8'hA5, 8, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 0);
    step(1, 8'h3C, 8, 0, 0, 0);
    run_out(0);
    step(1, 8'b10100, 5, 0, 0, 0);
    run_out(1);
    step(1, 8'hC3, 8, 15, 15, 0);
    run_out(1);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 10),
           $urandom_range(0, 7) == 0 ? 15 : $urandom_range(0, 3),
           $urandom_range(0, 7) == 0 ? 15 : $urandom_range(0, 3),
           $urandom_range(0, 199) == 0);
    step(0, '0, 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
